// File: rtl/dpsk_pkg.sv
// Shared defaults and sine-table generation for the DPSK carrier NCO.
// Table math is integer fixed point so it folds at elaboration.
package dpsk_pkg;

    localparam int DEF_PHASE_W = 16;
    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_SPS_W   = 8;

    localparam int     FX_BITS = 28;
    localparam longint FX_ONE  = longint'(1) << FX_BITS;
    localparam longint FX_PI   = 64'sd843314857;

    function automatic int midscale(input int data_w);
        return 1 << (data_w - 1);
    endfunction

    // mid + round((mid-1) * sin(2*pi*k/2^addr_w)), quarter-wave folded
    function automatic int sine_entry(
        input int k,
        input int addr_w,
        input int data_w
    );
        longint n;
        longint qtr;
        longint q;
        longint r;
        longint m;
        longint a;
        longint a2;
        longint term;
        longint sum;
        longint amp;
        longint mag;
        n    = longint'(1) << addr_w;
        qtr  = n >> 2;
        q    = longint'(k) / qtr;
        r    = longint'(k) % qtr;
        m    = ((q % 2) == 0) ? r : qtr - r;
        a    = (2 * FX_PI * m) / n;
        a2   = (a * a) >>> FX_BITS;
        term = a;
        sum  = a;
        for (int i = 1; i <= 10; i++) begin
            term = -((term * a2) >>> FX_BITS) / longint'((2 * i) * (2 * i + 1));
            sum  = sum + term;
        end
        amp = (longint'(1) << (data_w - 1)) - 1;
        mag = (amp * sum + (FX_ONE >>> 1)) >>> FX_BITS;
        if (q >= 2) begin
            return midscale(data_w) - int'(mag);
        end
        return midscale(data_w) + int'(mag);
    endfunction

endpackage

// File: rtl/dpsk_sine_rom.sv
// Full-cycle offset-binary sine table with registered, enabled read.
// Output resets to midscale and holds while the read enable is low.
module dpsk_sine_rom
    import dpsk_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] data_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [DATA_W-1:0] MID = DATA_W'(midscale(DATA_W));

    logic [DATA_W-1:0] tbl [DEPTH];
    logic [DATA_W-1:0] data_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_tbl
        localparam logic [DATA_W-1:0] ENTRY =
            DATA_W'(sine_entry(g, ADDR_W, DATA_W));
        assign tbl[g] = ENTRY;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= MID;
        end else if (en_i) begin
            data_q <= tbl[addr_i];
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/dpsk_carrier_nco.sv
// DPSK carrier NCO: phase accumulator, symbol timing, one-bit symbol
// buffer and differential 180-degree phase flip into a sine table.
module dpsk_carrier_nco
    import dpsk_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SPS_W   = DEF_SPS_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [PHASE_W-1:0] fcw,
    input  logic [SPS_W-1:0]   sps,
    input  logic               sym_valid,
    input  logic               sym_data,
    output logic               sym_ready,
    output logic [DATA_W-1:0]  dout,
    output logic               dout_valid,
    output logic               sym_start,
    output logic               underrun
);

    localparam logic [ADDR_W-1:0] HALF = ADDR_W'(1 << (ADDR_W - 1));

    logic [PHASE_W-1:0] acc_q;
    logic [PHASE_W-1:0] acc_d;
    logic [SPS_W-1:0]   cnt_q;
    logic [SPS_W-1:0]   cnt_d;
    logic [SPS_W-1:0]   len_q;
    logic [SPS_W-1:0]   len_d;
    logic [SPS_W-1:0]   len_eff;
    logic [SPS_W-1:0]   last_idx;
    logic               fresh_q;
    logic               flip_q;
    logic               flip_d;
    logic               full_q;
    logic               full_d;
    logic               bit_q;
    logic               bit_d;
    logic               valid_q;
    logic               start_q;
    logic               under_q;
    logic               bnd;
    logic               load;
    logic [ADDR_W-1:0]  addr;

    // fresh_q marks the first clock after reset, where sps is taken live
    always_comb begin
        len_eff  = fresh_q ? sps : len_q;
        last_idx = (len_eff == '0) ? '0 : len_eff - SPS_W'(1);
        bnd      = enable && (cnt_q == last_idx);
        load     = sym_valid && sym_ready;
        acc_d    = enable ? acc_q + fcw : acc_q;
        cnt_d    = cnt_q;
        if (enable) begin
            cnt_d = bnd ? '0 : cnt_q + SPS_W'(1);
        end
        len_d  = (fresh_q || bnd) ? sps : len_q;
        flip_d = flip_q;
        full_d = full_q;
        bit_d  = bit_q;
        if (bnd && full_q) begin
            flip_d = flip_q ^ bit_q;
            full_d = 1'b0;
        end
        if (load) begin
            bit_d  = sym_data;
            full_d = 1'b1;
        end
        addr = acc_q[PHASE_W-1 -: ADDR_W] + (flip_q ? HALF : '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            fresh_q <= 1'b1;
            flip_q  <= 1'b0;
            full_q  <= 1'b0;
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            under_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            fresh_q <= 1'b0;
            flip_q  <= flip_d;
            full_q  <= full_d;
            bit_q   <= bit_d;
            valid_q <= enable;
            start_q <= enable && (cnt_q == '0);
            under_q <= bnd && !full_q;
        end
    end

    dpsk_sine_rom #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rom (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (enable),
        .addr_i  (addr),
        .data_o  (dout)
    );

    assign sym_ready  = !fresh_q && !full_q;
    assign dout_valid = valid_q;
    assign sym_start  = start_q;
    assign underrun   = under_q;

endmodule

// File: tb/tb_dpsk_carrier_nco.sv
// Directed bench for dpsk_carrier_nco with a behavioural model feeding
// a per-cycle expectation queue plus fixed table-value checkpoints.
module tb_dpsk_carrier_nco;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [15:0] fcw;
    logic [7:0]  sps;
    logic        sym_valid;
    logic        sym_data;
    logic        sym_ready;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        sym_start;
    logic        underrun;

    always #5 clk = ~clk;

    dpsk_carrier_nco #(
        .PHASE_W (16),
        .ADDR_W  (5),
        .DATA_W  (8),
        .SPS_W   (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .fcw        (fcw),
        .sps        (sps),
        .sym_valid  (sym_valid),
        .sym_data   (sym_data),
        .sym_ready  (sym_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .sym_start  (sym_start),
        .underrun   (underrun)
    );

    typedef struct packed {
        logic [7:0] dout;
        logic       valid;
        logic       start;
        logic       under;
        logic       ready;
    } exp_t;

    exp_t  sb[$];
    int    tests = 0;
    int    fails = 0;
    int    tbl[32];
    string cur = "init";

    int m_acc, m_cnt, m_len, m_fresh, m_flip, m_full, m_bit, m_dout;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_cnt = 0; m_len = 0; m_fresh = 1;
        m_flip = 0; m_full = 0; m_bit = 0; m_dout = 128;
    endtask

    // predict this edge from the spec behaviour, then compare after it
    task automatic tick();
        exp_t e;
        int   n;
        int   last;
        int   rdy;
        int   bnd;
        n    = m_fresh ? int'(sps) : m_len;
        last = (n == 0) ? 0 : n - 1;
        rdy  = (!m_fresh && !m_full) ? 1 : 0;
        bnd  = (enable && m_cnt == last) ? 1 : 0;
        if (enable)
            m_dout = tbl[((m_acc >> 11) + (m_flip ? 16 : 0)) % 32];
        e.dout  = 8'(m_dout);
        e.valid = enable;
        e.start = enable && (m_cnt == 0);
        e.under = (bnd != 0) && (m_full == 0);
        if (m_fresh || bnd) m_len = int'(sps);
        if (enable) begin
            m_acc = (m_acc + int'(fcw)) % 65536;
            m_cnt = bnd ? 0 : m_cnt + 1;
        end
        if (bnd && m_full) begin
            m_flip = m_flip ^ m_bit;
            m_full = 0;
        end
        if (sym_valid && rdy) begin
            m_bit  = int'(sym_data);
            m_full = 1;
        end
        m_fresh = 0;
        e.ready = (m_full == 0);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({cur, "/queue"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({cur, "/dout"}, dout, e.dout);
            chk({cur, "/dout_valid"}, dout_valid, e.valid);
            chk({cur, "/sym_start"}, sym_start, e.start);
            chk({cur, "/underrun"}, underrun, e.under);
            chk({cur, "/sym_ready"}, sym_ready, e.ready);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        for (int k = 0; k < 32; k++) begin
            real s;
            s = 127.0 * $sin(2.0 * 3.141592653589793 * k / 32.0);
            tbl[k] = 128 + ((s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(-s + 0.5));
        end

        reset_n = 1'b0; enable = 1'b0; fcw = 16'h0800; sps = 8'd32;
        sym_valid = 1'b0; sym_data = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", dout, 128);
        chk("rst_valid", dout_valid, 0);
        chk("rst_ready", sym_ready, 0);
        chk("rst_start", sym_start, 0);
        chk("rst_underrun", underrun, 0);

        reset_n = 1'b1;
        cur = "release";
        tick();
        chk("ready_after_release", sym_ready, 1);

        cur = "sweep"; enable = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (i == 0) begin
                chk("sweep_e0", dout, 128);
                chk("sweep_start", sym_start, 1);
            end
            if (i == 8)  chk("sweep_e8", dout, 255);
            if (i == 16) chk("sweep_e16", dout, 128);
            if (i == 24) chk("sweep_e24", dout, 1);
            if (i == 31) chk("sweep_underrun", underrun, 1);
        end

        cur = "sym2"; sym_valid = 1'b1; sym_data = 1'b0;
        tick();
        sym_valid = 1'b0;
        run(31);
        cur = "sym3";
        tick();
        chk("d0_first", dout, 128);
        chk("d0_start", sym_start, 1);
        tick();
        chk("d0_second", dout, 153);
        sym_valid = 1'b1; sym_data = 1'b1;
        tick();
        sym_valid = 1'b0;
        run(29);
        cur = "sym4";
        tick();
        chk("d1_first", dout, 128);
        chk("d1_start", sym_start, 1);
        tick();
        chk("d1_second", dout, 103);
        run(30);
        chk("ur_pulse", underrun, 1);

        cur = "sym5";
        tick();
        chk("ur_once", underrun, 0);
        tick();
        chk("ur_flip_held", dout, 103);
        run(29);
        sym_valid = 1'b1; sym_data = 1'b1;
        tick();
        sym_valid = 1'b0;
        chk("ur_late_load", underrun, 1);
        chk("late_ready", sym_ready, 0);
        cur = "sym6";
        run(1);
        tick();
        chk("late_not_applied", dout, 103);
        run(30);
        cur = "sym7";
        run(1);
        tick();
        chk("late_applied", dout, 153);

        cur = "gap"; enable = 1'b0;
        run(5);
        chk("gap_held", dout, 153);
        chk("gap_valid", dout_valid, 0);
        enable = 1'b1;
        run(29);
        chk("gap_no_early", underrun, 0);
        tick();
        chk("gap_boundary", underrun, 1);

        cur = "sps_change";
        tick();
        chk("sym8_start", sym_start, 1);
        sps = 8'd8;
        run(30);
        chk("len_old_mid", underrun, 0);
        tick();
        chk("len_old_end", underrun, 1);
        tick();
        chk("len_new_start", sym_start, 1);
        sps = 8'd0;
        run(7);
        chk("len_new_end", underrun, 1);

        cur = "sps0";
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("sps0_start", sym_start, 1);
            chk("sps0_underrun", underrun, 1);
        end
        sps = 8'd32;
        run(4);

        cur = "mid_reset"; sym_valid = 1'b1; sym_data = 1'b1;
        tick();
        sym_valid = 1'b0;
        run(2);
        chk("full_before_reset", sym_ready, 0);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("mrst_dout", dout, 128);
        chk("mrst_valid", dout_valid, 0);
        chk("mrst_ready", sym_ready, 0);
        chk("mrst_start", sym_start, 0);
        chk("mrst_underrun", underrun, 0);
        #2;
        reset_n = 1'b1;
        cur = "after_reset";
        tick();
        chk("ar_dout", dout, 128);
        chk("ar_start", sym_start, 1);
        chk("ar_underrun", underrun, 0);
        chk("ar_ready", sym_ready, 1);
        tick();
        chk("ar_second", dout, 153);
        run(29);
        tick();
        chk("ar_boundary", underrun, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
